// File: rtl/uart_pkg.sv
// Shared UART definitions: frame timing helpers and the transmit-side state encoding.
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;

    typedef enum logic {
        IDLE = 1'b0,
        TX   = 1'b1
    } state_t;

    // The result is truncated, so the real line rate is slightly above the nominal baud rate.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any,
    output logic [IW-1:0]      winner
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        // k == NUM_REQ wraps back onto ptr itself, so a lone previous winner still gets served.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter; grant -> enable/ready one cycle after the decision.
// Requests are ignored while a frame is timed out locally (no busy flag from the transmitter).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FRAME_BITS = UART_FRAME_BITS,
    parameter int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_50m,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_enable,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    localparam int CW           = $clog2(FRAME_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES);

    if (FRAME_CYCLES < 2 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_check
        $error("uart_tx_arbiter: need FRAME_CYCLES >= 2 and 2 <= NUM_REQ <= 8");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic          any;
    logic [7:0]    data_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[8*i +: 8];
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            ptr            <= IW'(NUM_REQ - 1);
            req_ready      <= '0;
            uart_tx_data   <= '0;
            uart_tx_enable <= 1'b0;
            busy           <= 1'b0;
            grant_id       <= '0;
        end else begin
            req_ready      <= '0;
            uart_tx_enable <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (any) begin
                        uart_tx_data   <= data_arr[winner];
                        ptr            <= winner;
                        grant_id       <= winner;
                        req_ready      <= NUM_REQ'(1) << winner;
                        uart_tx_enable <= 1'b1;
                        busy           <= 1'b1;
                        cnt            <= CW'(1);
                        state          <= TX;
                    end
                end
                TX: begin
                    // The enable cycle counts as frame cycle 1, so busy spans exactly FRAME_CYCLES.
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int FC = 10 * (1000 / 100);

    logic           clk_50m = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_tx_data;
    logic           uart_tx_enable;
    logic           busy;
    logic [0:0]     grant_id;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FRAME_BITS (10)
    ) dut (
        .clk_50m        (clk_50m),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_enable (uart_tx_enable),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    always #5 clk_50m = ~clk_50m;

    int n_assert = 0;
    int n_fail   = 0;

    // Frame-level model: the line is free from m_free on; the last winner sets the RR start.
    int         now      = 0;
    int         m_free   = 0;
    int         m_launch = 0;
    int         m_last   = N - 1;
    int         m_grant  = 0;
    logic [7:0] m_data   = '0;
    int         n_en     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, now);
        end
    endtask

    task automatic model_reset();
        m_free   = now;
        m_launch = now;
        m_last   = N - 1;
        m_grant  = 0;
        m_data   = '0;
    endtask

    task automatic tick(input logic [N-1:0] v, input logic [8*N-1:0] d);
        logic         exp_en;
        logic [N-1:0] exp_rdy;
        bit           found;
        int           w;
        req_valid = v;
        req_data  = d;
        exp_en  = 1'b0;
        exp_rdy = '0;
        found   = 0;
        if (now >= m_free && v != '0) begin
            for (int k = 1; k <= N; k++) begin
                w = (m_last + k) % N;
                if (!found && v[w]) begin
                    found    = 1;
                    exp_en   = 1'b1;
                    exp_rdy  = N'(1) << w;
                    m_data   = 8'(d >> (8 * w));
                    m_last   = w;
                    m_grant  = w;
                    m_launch = now + 1;
                    m_free   = now + 1 + FC;
                end
            end
        end
        @(posedge clk_50m);
        #1;
        now++;
        if (uart_tx_enable === 1'b1) n_en++;
        check("enable", 32'(uart_tx_enable), 32'(exp_en));
        check("ready", 32'(req_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(now >= m_launch && now < m_free));
        check("data", 32'(uart_tx_data), 32'(m_data));
        check("grant_id", 32'(grant_id), 32'(m_grant));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, '0);
    endtask

    // Hold valid/data until the ready bit shows up, bounded.
    task automatic hold_until_ready(input logic [N-1:0] v, input logic [8*N-1:0] d, input int who);
        int guard;
        guard = 0;
        tick(v, d);
        while (req_ready[who] !== 1'b1 && guard < 3 * FC) begin
            tick(v, d);
            guard++;
        end
        check("hold_bound", 32'(req_ready[who]), 32'd1);
    endtask

    task automatic reset_check();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_enable", 32'(uart_tx_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(uart_tx_data), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
    endtask

    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        #1;
        reset_check();
        model_reset();
        @(posedge clk_50m);
        #1;
        reset_n = 1'b1;
    endtask

    logic [N-1:0]   pend;
    logic [8*N-1:0] pdat;
    int             en_before;
    logic [7:0]     seq;

    initial begin
        #3;
        reset_check();
        @(posedge clk_50m);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Single request, then idle until well past the frame end.
        idle(4);
        hold_until_ready(2'b01, 16'h00A5, 0);
        idle(FC + 5);

        // Contention: both continuously valid, four frames alternate 0,1,0,1.
        en_before = n_en;
        for (int i = 0; i < 4 * (FC + 1); i++) tick(2'b11, 16'h2211);
        check("contention_frames", 32'(n_en - en_before), 32'd4);
        idle(FC + 2);

        // Request from 1 arriving mid-frame waits for the next decision cycle.
        hold_until_ready(2'b01, 16'h0033, 0);
        idle(29);
        hold_until_ready(2'b10, 16'h4400, 1);
        idle(FC + 2);

        // Request from 0 withdrawn during a frame is never served.
        hold_until_ready(2'b10, 16'h5500, 1);
        idle(29);
        for (int i = 0; i < 11; i++) tick(2'b01, 16'h0066);
        en_before = n_en;
        idle(FC);
        check("withdrawn_no_enable", 32'(n_en - en_before), 32'd0);

        // Reset mid-frame, then requester 1 alone, then both pending after a second reset.
        hold_until_ready(2'b01, 16'h0077, 0);
        idle(49);
        pulse_reset();
        hold_until_ready(2'b10, 16'h8800, 1);
        idle(20);
        pulse_reset();
        hold_until_ready(2'b11, 16'h9A99, 0);
        idle(FC + 2);

        // Back-to-back single requester: data 01,02,03 re-asserted right after ready.
        en_before = n_en;
        seq = 8'h01;
        for (int i = 0; i < 3 * (FC + 1) && seq != 8'h04; i++) begin
            tick(2'b01, {8'h00, seq});
            if (req_ready[0] === 1'b1) seq = seq + 8'h01;
        end
        idle(FC + 2);
        check("b2b_frames", 32'(n_en - en_before), 32'd3);

        // Randomized producers: sticky valid, occasional withdrawal and data change.
        pend = '0;
        pdat = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && req_ready[i] === 1'b1) begin
                    pend[i] = ($urandom_range(0, 3) == 0);
                    pdat[8*i +: 8] = 8'($urandom);
                end else if (!pend[i] && $urandom_range(0, 29) == 0) begin
                    pend[i] = 1'b1;
                    pdat[8*i +: 8] = 8'($urandom);
                end else if (pend[i] && $urandom_range(0, 199) == 0) begin
                    pend[i] = 1'b0;
                end else if (pend[i] && $urandom_range(0, 49) == 0) begin
                    pdat[8*i +: 8] = 8'($urandom);
                end
            end
            tick(pend, pdat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx_path transmitter among NUM_REQ byte producers, for example the timer PPS second-count sender and a command-echo/status responder.
- Uses round-robin arbitration.
- uart_tx_path exposes no busy flag, so this block times each serial frame itself. It never issues uart_tx_enable while a frame is still on the line.
- Sits in top between the producers and u_uart_tx_path, replacing the ad-hoc level-sensitive enable logic.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CLK_FREQ, 50_000_000, clk_50m frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (434 at default)
FRAME_BITS, 10, start + 8 data + stop; FRAME_CYCLES = FRAME_BITS*CLKS_PER_BIT (4340 at default)

Ports:
clk_50m  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte pending; must be held with data until accepted
req_data  input  8*NUM_REQ  requester i byte on bits [8i+7:8i]
req_ready  output  NUM_REQ  one-cycle accept pulse, at most one bit set
uart_tx_data  output  8  byte to uart_tx_path, stable for the entire frame
uart_tx_enable  output  1  one-cycle start pulse to uart_tx_path
busy  output  1  high from the launch cycle through the last frame cycle
grant_id  output  clog2(NUM_REQ)  index of the last granted requester

Behaviour:
- Reset (async assert, sync release). All of the following are 0: req_ready, uart_tx_data, uart_tx_enable, busy, grant_id, frame counter. State is IDLE. The RR pointer is set to NUM_REQ-1, so requester 0 wins first.
- Mid-frame reset: abort immediately. The byte is lost and outputs return to reset values; no partial enable is issued.
- States: IDLE, TX.
- IDLE, cycle T, with req_valid != 0:
  - Pick the first set bit searching from (pointer+1) mod NUM_REQ upward with wrap.
  - At edge end of T: latch req_data[winner] into uart_tx_data; pointer and grant_id become winner; counter = 1; go to TX.
  - Cycle T+1: req_ready[winner]=1, uart_tx_enable=1, busy=1. All three are registered and last one cycle only.
- IDLE with req_valid == 0: hold. busy=0. uart_tx_data keeps its last value.
- TX:
  - Counter increments each cycle.
  - When counter == FRAME_CYCLES, go to IDLE at the next edge.
  - busy is high for exactly FRAME_CYCLES cycles, starting with the enable cycle.
  - req_valid is ignored in TX.
- Throughput: the minimum spacing between successive uart_tx_enable pulses is FRAME_CYCLES+1 cycles (the one IDLE decision cycle).
- Handshake: a requester holds valid and data until it sees its ready bit. It may drop valid the cycle after ready.
  - A valid dropped before it is granted is not an error; that requester is simply skipped.
  - Data changes before grant are allowed; the value sampled at the grant edge is sent.
- Simultaneous requests: strict RR. With all requesters continuously valid, the grant order is 0,1,...,NUM_REQ-1,0,...
- Requester re-asserting valid immediately after ready: it is eligible at the next IDLE, behind others per RR.
- Elaboration check: FRAME_CYCLES >= 2 and 2 <= NUM_REQ <= 8; otherwise $error.
- Counter width: clog2(FRAME_CYCLES+1). No wrap is possible because the counter stops at the terminal count.

Decomposition:
- Shared package uart_pkg: function clks_per_bit(clk_freq, baud); localparam UART_FRAME_BITS=10; state enum {IDLE, TX}.
- The same package and clks_per_bit function are to be reused by uart_tx_path/uart_rx_path later.
- One sub-module: rr_pick. It is combinational and holds no pointer state, which stays in the parent.
  - Inputs: req vector, pointer.
  - Outputs: any, winner index.

Test Plan:
Use CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10 and FRAME_CYCLES=100; NUM_REQ=2.
1. Single request: req_valid=2'b01, data0=8'hA5 at cycle 5 -> cycle 6: req_ready=01, uart_tx_enable=1, uart_tx_data=A5; busy high cycles 6..105; uart_tx_data stays A5 throughout; IDLE at 106.
2. Contention: both valid continuously, data0=11, data1=22 -> enables at cycles N, N+101, N+202, N+303 carry 11,22,11,22; grant_id alternates 0,1,0,1.
3. Request during frame: req1 asserted at cycle 30 while requester 0's frame runs -> ignored until IDLE; req_ready[1] and enable at cycle 107 with data1.
4. Withdrawn request: req0 valid cycles 30..40 during a busy frame, then dropped -> no ready[0] and no enable after the frame; busy=0 from 106.
5. Reset mid-frame: reset_n low at cycle 50 of a frame -> busy, enable, ready and data go to 0 asynchronously; after release, a fresh request to requester 1 is granted after at most 2 cycles, and requester 0 wins first when both are pending.
6. Back-to-back single requester: req0 re-asserted the cycle after ready with 8'h01, 8'h02, 8'h03 -> enables spaced exactly 101 cycles apart with data 01, 02, 03 and no extra pulses.
